// File: rtl/ssd_view_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssd_view_scheduler
// Purpose  : Steps the processor's debug-view select through a user-enabled
//            set of seven-segment views. Views advance on a dwell timer (auto
//            mode) or on a debounced push-button. The returned 13-bit value
//            is registered and frozen for a settle window after every view
//            change, so the display driver never shows a stale value.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            auto_en    - 1 = timer-driven rotation, 0 = manual only
//            btn_next   - raw push-button (async, active-high)
//            view_mask  - bit i enables ssd_sel value i in the rotation
//            ssd_in     - processor value for the current ssd_sel
//            ssd_sel    - view select to the processor
//            led_sel    - LED bank select to the processor
//            ssd_out    - value to the seven-segment driver
//            view_valid - ssd_out reflects the current ssd_sel
// Options  : SSD_SEQ_LED_LINK_EN - when defined, led_sel steps modulo 4 on
//            every wrap of the view rotation; otherwise led_sel is 2'b00.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_view_scheduler #(
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_en,
  input  logic        btn_next,
  input  logic [15:0] view_mask,
  input  logic [12:0] ssd_in,
  output logic [3:0]  ssd_sel,
  output logic [1:0]  led_sel,
  output logic [12:0] ssd_out,
  output logic        view_valid
);

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [DW_W-1:0] DWELL_LAST    = DW_W'(DWELL_CYCLES - 1);
  localparam logic [DB_W-1:0] DEBOUNCE_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] SETTLE_LAST   = ST_W'(SETTLE_CYCLES - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_SHOW   = 1'b1;

  // Button path
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            btn_level_q, btn_level_d;
  logic            btn_level_prev_q, btn_level_prev_d;
  logic            adv_man_q, adv_man_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Dwell timer and advance
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            adv_auto;
  logic            advance;

  // View selection
  logic [15:0]     eff_mask;
  logic [3:0]      next_sel;
  logic [3:0]      cand;
  logic            found;
  logic [3:0]      ssd_sel_q, ssd_sel_d;

  // Settle FSM and output register
  logic [0:0]      state_q, state_d;
  logic [ST_W-1:0] settle_cnt_q, settle_cnt_d;
  logic            settle_done;
  logic [12:0]     ssd_out_q, ssd_out_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q          <= 1'b0;
      sync2_q          <= 1'b0;
      btn_level_q      <= 1'b0;
      btn_level_prev_q <= 1'b0;
      adv_man_q        <= 1'b0;
      db_cnt_q         <= '0;
      dwell_q          <= '0;
      ssd_sel_q        <= 4'd0;
      state_q          <= ST_SETTLE;
      settle_cnt_q     <= '0;
      ssd_out_q        <= 13'd0;
    end else begin
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      btn_level_q      <= btn_level_d;
      btn_level_prev_q <= btn_level_prev_d;
      adv_man_q        <= adv_man_d;
      db_cnt_q         <= db_cnt_d;
      dwell_q          <= dwell_d;
      ssd_sel_q        <= ssd_sel_d;
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      ssd_out_q        <= ssd_out_d;
    end
  end

  // --------------------------------------------------------------------------
  // Button synchronizer and debounce. The counter only runs while the synced
  // sample disagrees with the accepted level; DEBOUNCE_CYCLES consecutive
  // disagreeing samples flip the level. The press pulse is registered once
  // more so it lines up one cycle after the level change.
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d          = btn_next;
    sync2_d          = sync1_q;
    btn_level_d      = btn_level_q;
    db_cnt_d         = '0;
    if (sync2_q != btn_level_q) begin
      if (db_cnt_q == DEBOUNCE_LAST) begin
        btn_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    btn_level_prev_d = btn_level_q;
    adv_man_d        = btn_level_q & ~btn_level_prev_q;
  end

  // --------------------------------------------------------------------------
  // Dwell timer. Any advance (manual or auto) restarts the full dwell.
  // --------------------------------------------------------------------------
  assign adv_auto = auto_en && (dwell_q == DWELL_LAST);
  assign advance  = adv_man_q | adv_auto;

  always_comb begin
    dwell_d = dwell_q + DW_W'(1);
    if (!auto_en || advance) begin
      dwell_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Next-view search: circular scan starting one past the current view. The
  // 16th candidate is the current view itself, so a single-bit mask yields
  // an unchanged select. An empty mask behaves as view 0 only.
  // --------------------------------------------------------------------------
  always_comb begin
    eff_mask = (view_mask == 16'h0000) ? 16'h0001 : view_mask;
    next_sel = ssd_sel_q;
    found    = 1'b0;
    cand     = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      cand = ssd_sel_q + 4'(k);
      if (!found && eff_mask[cand]) begin
        next_sel = cand;
        found    = 1'b1;
      end
    end
    ssd_sel_d = advance ? next_sel : ssd_sel_q;
  end

  // --------------------------------------------------------------------------
  // Settle FSM: next-state logic
  // --------------------------------------------------------------------------
  assign settle_done = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    if (advance) begin
      state_d      = ST_SETTLE;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_done) begin
            state_d      = ST_SHOW;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + ST_W'(1);
          end
        end
        ST_SHOW: begin
          state_d = ST_SHOW;
        end
        default: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Settle FSM: outputs. The capture on the final settle edge is the first
  // sample of the new view, coinciding with view_valid rising.
  // --------------------------------------------------------------------------
  always_comb begin
    ssd_out_d = ssd_out_q;
    if ((state_q == ST_SHOW) || (settle_done && !advance)) begin
      ssd_out_d = ssd_in;
    end
  end

  assign view_valid = (state_q == ST_SHOW);
  assign ssd_sel    = ssd_sel_q;
  assign ssd_out    = ssd_out_q;

  // --------------------------------------------------------------------------
  // LED bank link: a wrap is any advance whose target is not above the
  // current view, including the single-view case.
  // --------------------------------------------------------------------------
`ifdef SSD_SEQ_LED_LINK_EN
  logic       wrap;
  logic [1:0] led_sel_q, led_sel_d;

  assign wrap = advance && (next_sel <= ssd_sel_q);

  always_comb begin
    led_sel_d = wrap ? (led_sel_q + 2'd1) : led_sel_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_sel_q <= 2'd0;
    end else begin
      led_sel_q <= led_sel_d;
    end
  end

  assign led_sel = led_sel_q;
`else
  assign led_sel = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ssd_view_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_view_scheduler
// Purpose  : Directed self-checking bench for ssd_view_scheduler with
//            DWELL=8, DEBOUNCE=4, SETTLE=2. Expected led_sel follows the
//            SSD_SEQ_LED_LINK_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_view_scheduler;

`ifdef SSD_SEQ_LED_LINK_EN
  localparam bit LED_LINK = 1'b1;
`else
  localparam bit LED_LINK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        auto_en;
  logic        btn_next;
  logic [15:0] view_mask;
  logic [12:0] ssd_in;
  logic [3:0]  ssd_sel;
  logic [1:0]  led_sel;
  logic [12:0] ssd_out;
  logic        view_valid;

  int checks   = 0;
  int failures = 0;

  ssd_view_scheduler #(
    .DWELL_CYCLES    (8),
    .DEBOUNCE_CYCLES (4),
    .SETTLE_CYCLES   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .auto_en    (auto_en),
    .btn_next   (btn_next),
    .view_mask  (view_mask),
    .ssd_in     (ssd_in),
    .ssd_sel    (ssd_sel),
    .led_sel    (led_sel),
    .ssd_out    (ssd_out),
    .view_valid (view_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and release just after an edge; the next
  // rising edge is edge 1 of the test.
  task automatic apply_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; auto_en = 1'b0; btn_next = 1'b0;
    view_mask = 16'h8421; ssd_in = 13'h1FFF;
    tick(3);
    checks++; if (ssd_sel !== 4'd0) begin failures++; $display("FAIL reset_ssd_sel got=%h exp=0", ssd_sel); end
    checks++; if (led_sel !== 2'd0) begin failures++; $display("FAIL reset_led_sel got=%h exp=0", led_sel); end
    checks++; if (ssd_out !== 13'd0) begin failures++; $display("FAIL reset_ssd_out got=%h exp=0", ssd_out); end
    checks++; if (view_valid !== 1'b0) begin failures++; $display("FAIL reset_view_valid got=%b exp=0", view_valid); end
  endtask

  task automatic test_mask_zero();
    logic       exp_v;
    logic [1:0] exp_led;
    auto_en = 1'b1; view_mask = 16'h0000; ssd_in = 13'h0011;
    apply_reset();
    for (int e = 1; e <= 26; e++) begin
      tick(1);
      exp_v   = !(((e % 8) == 0) || ((e % 8) == 1));
      exp_led = LED_LINK ? 2'((e / 8) % 4) : 2'd0;
      checks++; if (ssd_sel !== 4'd0) begin failures++; $display("FAIL mask0_sel e=%0d got=%h exp=0", e, ssd_sel); end
      checks++; if (view_valid !== exp_v) begin failures++; $display("FAIL mask0_valid e=%0d got=%b exp=%b", e, view_valid, exp_v); end
      checks++; if (led_sel !== exp_led) begin failures++; $display("FAIL mask0_led e=%0d got=%h exp=%h", e, led_sel, exp_led); end
    end
  endtask

  task automatic test_auto_rotation();
    logic [3:0] exp_sel;
    logic [1:0] exp_led;
    auto_en = 1'b1; view_mask = 16'h8421;
    apply_reset();
    for (int e = 1; e <= 36; e++) begin
      tick(1);
      exp_sel = 4'(((e / 8) % 4) * 5);
      exp_led = (LED_LINK && e >= 32) ? 2'd1 : 2'd0;
      checks++; if (ssd_sel !== exp_sel) begin failures++; $display("FAIL auto_sel e=%0d got=%h exp=%h", e, ssd_sel, exp_sel); end
      checks++; if (led_sel !== exp_led) begin failures++; $display("FAIL auto_led e=%0d got=%h exp=%h", e, led_sel, exp_led); end
    end
  endtask

  task automatic test_button_debounce();
    logic [3:0] exp_sel;
    logic       exp_v;
    auto_en = 1'b0; view_mask = 16'h8421; btn_next = 1'b0;
    apply_reset();
    tick(3);
    // Three-cycle bounce must be rejected.
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      checks++; if (ssd_sel !== 4'd0) begin failures++; $display("FAIL bounce_sel e=%0d got=%h exp=0", e, ssd_sel); end
    end
    // Ten-cycle clean press: one advance, select updates 8 edges later.
    btn_next = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick(1);
      exp_sel = (e >= 8) ? 4'd5 : 4'd0;
      exp_v   = !(e == 8 || e == 9);
      checks++; if (ssd_sel !== exp_sel) begin failures++; $display("FAIL press_sel e=%0d got=%h exp=%h", e, ssd_sel, exp_sel); end
      checks++; if (view_valid !== exp_v) begin failures++; $display("FAIL press_valid e=%0d got=%b exp=%b", e, view_valid, exp_v); end
      if (e == 10) btn_next = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_sel;
    logic [1:0] exp_led;
    auto_en = 1'b1; view_mask = 16'h0006;
    apply_reset();
    for (int e = 1; e <= 26; e++) begin
      tick(1);
      if (e < 8)       exp_sel = 4'd0;
      else if (e < 16) exp_sel = 4'd1;
      else if (e < 24) exp_sel = 4'd2;
      else             exp_sel = 4'd1;
      exp_led = (LED_LINK && e >= 24) ? 2'd1 : 2'd0;
      checks++; if (ssd_sel !== exp_sel) begin failures++; $display("FAIL wrap_sel e=%0d got=%h exp=%h", e, ssd_sel, exp_sel); end
      checks++; if (led_sel !== exp_led) begin failures++; $display("FAIL wrap_led e=%0d got=%h exp=%h", e, led_sel, exp_led); end
    end
  endtask

  task automatic test_settle_hold();
    auto_en = 1'b0; view_mask = 16'h8421; btn_next = 1'b0; ssd_in = 13'h1ABC;
    apply_reset();
    tick(4);
    checks++; if (ssd_out !== 13'h1ABC) begin failures++; $display("FAIL settle_pre_out got=%h exp=1abc", ssd_out); end
    checks++; if (view_valid !== 1'b1) begin failures++; $display("FAIL settle_pre_valid got=%b exp=1", view_valid); end
    btn_next = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      case (e)
        7: begin
          checks++; if (ssd_sel !== 4'd0) begin failures++; $display("FAIL settle_sel7 got=%h exp=0", ssd_sel); end
        end
        8: begin
          checks++; if (ssd_sel !== 4'd5) begin failures++; $display("FAIL settle_sel8 got=%h exp=5", ssd_sel); end
          checks++; if (ssd_out !== 13'h1ABC) begin failures++; $display("FAIL settle_out8 got=%h exp=1abc", ssd_out); end
          checks++; if (view_valid !== 1'b0) begin failures++; $display("FAIL settle_valid8 got=%b exp=0", view_valid); end
          ssd_in = 13'h0123;
        end
        9: begin
          checks++; if (ssd_out !== 13'h1ABC) begin failures++; $display("FAIL settle_out9 got=%h exp=1abc", ssd_out); end
          checks++; if (view_valid !== 1'b0) begin failures++; $display("FAIL settle_valid9 got=%b exp=0", view_valid); end
        end
        10: begin
          checks++; if (ssd_out !== 13'h0123) begin failures++; $display("FAIL settle_out10 got=%h exp=0123", ssd_out); end
          checks++; if (view_valid !== 1'b1) begin failures++; $display("FAIL settle_valid10 got=%b exp=1", view_valid); end
          btn_next = 1'b0;
        end
        11: begin
          checks++; if (ssd_out !== 13'h0123) begin failures++; $display("FAIL show_out11 got=%h exp=0123", ssd_out); end
          ssd_in = 13'h0FFF;
        end
        12: begin
          checks++; if (ssd_out !== 13'h0FFF) begin failures++; $display("FAIL show_out12 got=%h exp=0fff", ssd_out); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_sel;
    auto_en = 1'b1; view_mask = 16'h8421; ssd_in = 13'h0555;
    apply_reset();
    tick(8);
    checks++; if (ssd_sel !== 4'd5) begin failures++; $display("FAIL mid_pre_sel got=%h exp=5", ssd_sel); end
    checks++; if (ssd_out !== 13'h0555) begin failures++; $display("FAIL mid_pre_out got=%h exp=0555", ssd_out); end
    tick(1);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (ssd_sel !== 4'd0) begin failures++; $display("FAIL mid_rst_sel got=%h exp=0", ssd_sel); end
    checks++; if (led_sel !== 2'd0) begin failures++; $display("FAIL mid_rst_led got=%h exp=0", led_sel); end
    checks++; if (ssd_out !== 13'd0) begin failures++; $display("FAIL mid_rst_out got=%h exp=0", ssd_out); end
    checks++; if (view_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", view_valid); end
    tick(2);
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      exp_sel = (e >= 8) ? 4'd5 : 4'd0;
      checks++; if (ssd_sel !== exp_sel) begin failures++; $display("FAIL mid_post_sel e=%0d got=%h exp=%h", e, ssd_sel, exp_sel); end
    end
  endtask

  initial begin
    reset = 1'b0; auto_en = 1'b0; btn_next = 1'b0;
    view_mask = 16'h0000; ssd_in = 13'h0000;
    test_reset();
    test_mask_zero();
    test_auto_rotation();
    test_button_debounce();
    test_wrap();
    test_settle_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
